// File: rtl/led_pattern_pkg.sv
// ============================================================================
// Module : led_pattern_pkg
// Brief  : Shared mode and direction encodings for the LED pattern generator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

`default_nettype wire

// File: rtl/led_tick_prescaler.sv
// ============================================================================
// Module : led_tick_prescaler
// Brief  : Divides clk by DIV and emits a registered one-cycle tick pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_tick_prescaler #(
    parameter int DIV = 262144
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int              c_CW  = $clog2(DIV);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_presc;
    logic            r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (enable) begin
            r_tick  <= (r_presc == c_MAX);
            r_presc <= (r_presc == c_MAX) ? '0 : r_presc + 1'b1;
        end else begin
            r_tick  <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// Module : led_pattern_gen
// Brief  : Programmable LED pattern generator (binary / scan / breathe / off).
//          Define LED_ACTIVE_LOW_EN for boards with active-low LEDs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int DIV      = 262144,
    parameter int PWM_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic                tick,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int                   c_POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [c_POS_W-1:0]   c_POS_MAX  = c_POS_W'(NUM_LEDS - 1);
    localparam logic [PWM_W-1:0]     c_DUTY_MAX = '1;
    localparam logic [NUM_LEDS-1:0]  c_ONE      = NUM_LEDS'(1);
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [NUM_LEDS-1:0]  c_INV      = '1;
`else
    localparam logic [NUM_LEDS-1:0]  c_INV      = '0;
`endif

    mode_t               r_active_mode;
    logic [NUM_LEDS-1:0] r_step;
    logic [c_POS_W-1:0]  r_pos;
    dir_t                r_scan_dir;
    logic [PWM_W-1:0]    r_duty;
    dir_t                r_breathe_dir;
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_leds;
    logic [NUM_LEDS-1:0] w_leds;
    logic                w_tick;

    led_tick_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_mode <= MODE_BINARY;
            r_step        <= '0;
            r_pos         <= '0;
            r_scan_dir    <= DIR_UP;
            r_duty        <= '0;
            r_breathe_dir <= DIR_UP;
            r_pwm_cnt     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_tick) begin
                // A mode change consumes its tick; the new pattern starts from its origin.
                if (mode_t'(mode) != r_active_mode) begin
                    r_active_mode <= mode_t'(mode);
                    r_step        <= '0;
                    r_pos         <= '0;
                    r_scan_dir    <= DIR_UP;
                    r_duty        <= '0;
                    r_breathe_dir <= DIR_UP;
                end else begin
                    case (r_active_mode)
                        MODE_BINARY: r_step <= r_step + 1'b1;
                        MODE_SCAN: begin
                            if (NUM_LEDS > 1) begin
                                if (r_scan_dir == DIR_UP) begin
                                    if (r_pos == c_POS_MAX) begin
                                        r_scan_dir <= DIR_DOWN;
                                        r_pos      <= r_pos - 1'b1;
                                    end else begin
                                        r_pos      <= r_pos + 1'b1;
                                    end
                                end else begin
                                    if (r_pos == '0) begin
                                        r_scan_dir <= DIR_UP;
                                        r_pos      <= r_pos + 1'b1;
                                    end else begin
                                        r_pos      <= r_pos - 1'b1;
                                    end
                                end
                            end
                        end
                        MODE_BREATHE: begin
                            if (r_breathe_dir == DIR_UP) begin
                                if (r_duty == c_DUTY_MAX) begin
                                    r_breathe_dir <= DIR_DOWN;
                                    r_duty        <= r_duty - 1'b1;
                                end else begin
                                    r_duty        <= r_duty + 1'b1;
                                end
                            end else begin
                                if (r_duty == '0) begin
                                    r_breathe_dir <= DIR_UP;
                                    r_duty        <= r_duty + 1'b1;
                                end else begin
                                    r_duty        <= r_duty - 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_leds = '0;
        case (r_active_mode)
            MODE_BINARY:  w_leds = r_step;
            MODE_SCAN:    w_leds = c_ONE << r_pos;
            MODE_BREATHE: w_leds = {NUM_LEDS{r_pwm_cnt < r_duty}};
            default:      w_leds = '0;
        endcase
    end

    // Polarity is applied before the register so the pad sees a flop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= c_INV;
        end else begin
            r_leds <= w_leds ^ c_INV;
        end
    end

    assign leds = r_leds;
    assign tick = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
// ============================================================================
// Module : tb_led_pattern_gen
// Brief  : Directed bench for led_pattern_gen (honours LED_ACTIVE_LOW_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_gen;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [7:0] c_INV = 8'hFF;
`else
    localparam logic [7:0] c_INV = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, enable_br;
    logic [1:0] mode, mode_br;
    logic       tick, tick_br;
    logic [7:0] leds, leds_br;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] scan_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    int duty_exp [31] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                          14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    always #5 clk = ~clk;

    led_pattern_gen #(.NUM_LEDS(8), .DIV(4), .PWM_W(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .mode   (mode),
        .tick   (tick),
        .leds   (leds)
    );

    led_pattern_gen #(.NUM_LEDS(8), .DIV(64), .PWM_W(4)) u_dut_br (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable_br),
        .mode   (mode_br),
        .tick   (tick_br),
        .leds   (leds_br)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of falling edges until tick is seen high.
    task automatic wait_tick(input bit sel, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? tick_br : tick) !== 1'b1) && (n < budget));
        if ((sel ? tick_br : tick) !== 1'b1)
            check_eq("tick_timeout", 32'd0, 32'd1);
    endtask

    // Wait for a tick, then for the state update and the output register.
    task automatic step_leds(input bit sel);
        int n;
        wait_tick(sel, 200, n);
        repeat (2) @(negedge clk);
    endtask

    task automatic count_on(output int c);
        c = 0;
        repeat (16) begin
            @(negedge clk);
            if ((leds_br[0] ^ c_INV[0]) == 1'b1) c++;
        end
    endtask

    initial begin
        int  n;
        int  c;
        bit  bad_leds;
        bit  bad_tick;

        rst_n     = 1'b0;
        enable    = 1'b1;
        enable_br = 1'b0;
        mode      = 2'd0;
        mode_br   = 2'd2;
        repeat (3) @(negedge clk);
        check_eq("rst_leds",    leds,    c_INV);
        check_eq("rst_tick",    tick,    0);
        check_eq("rst_leds_br", leds_br, c_INV);

        // Binary count
        rst_n = 1'b1;
        wait_tick(0, 20, n);
        check_eq("first_tick_lat", n, 4);
        @(negedge clk);
        check_eq("bin_leds_lat", leds, 8'h00 ^ c_INV);
        @(negedge clk);
        check_eq("bin_1", leds, 8'h01 ^ c_INV);
        step_leds(0);
        check_eq("bin_2", leds, 8'h02 ^ c_INV);
        step_leds(0);
        check_eq("bin_3", leds, 8'h03 ^ c_INV);
        repeat (252) step_leds(0);
        check_eq("bin_ff", leds, 8'hFF ^ c_INV);
        step_leds(0);
        check_eq("bin_wrap", leds, 8'h00 ^ c_INV);

        // Scan
        mode = 2'd1;
        step_leds(0);
        check_eq("scan_switch", leds, 8'h01 ^ c_INV);
        for (int i = 0; i < 15; i++) begin
            step_leds(0);
            check_eq($sformatf("scan_%0d", i), leds, scan_exp[i] ^ c_INV);
        end
        repeat (4) step_leds(0);
        check_eq("scan_pos5", leds, 8'h20 ^ c_INV);

        // Freeze mid-scan
        enable   = 1'b0;
        bad_leds = 1'b0;
        bad_tick = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (leds !== (8'h20 ^ c_INV)) bad_leds = 1'b1;
            if (tick !== 1'b0)            bad_tick = 1'b1;
        end
        check_eq("freeze_leds", bad_leds, 0);
        check_eq("freeze_tick", bad_tick, 0);
        enable = 1'b1;
        wait_tick(0, 20, n);
        check_eq("resume_lat", n, 2);
        repeat (2) @(negedge clk);
        check_eq("resume_leds", leds, 8'h40 ^ c_INV);

        // Off
        mode = 2'd3;
        step_leds(0);
        check_eq("off_0", leds, 8'h00 ^ c_INV);
        step_leds(0);
        check_eq("off_1", leds, 8'h00 ^ c_INV);

        // Breathe on the slower instance
        enable_br = 1'b1;
        step_leds(1);
        count_on(c);
        check_eq("br_duty_init", c, 0);
        for (int i = 0; i < 31; i++) begin
            step_leds(1);
            count_on(c);
            check_eq($sformatf("br_duty_%0d", i), c, duty_exp[i]);
        end

        // Asynchronous reset between edges
        step_leds(1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_leds_br", leds_br, c_INV);
        check_eq("async_tick_br", tick_br, 0);
        check_eq("async_leds",    leds,    c_INV);
        check_eq("async_tick",    tick,    0);
        mode = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(0, 20, n);
        check_eq("post_rst_lat", n, 4);
        repeat (2) @(negedge clk);
        check_eq("post_rst_bin", leds, 8'h01 ^ c_INV);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
